// File: rtl/reg_bus_router.sv
// Routes received command frames to one of NUM_SLV register slaves with a
// four-phase valid/ack handshake, per-phase ack timeout and read-back capture.
module reg_bus_router #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 4,
  parameter int NUM_SLV = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_W+DATA_W-1:0]    frame,
  input  logic                        frame_valid,
  input  logic [NUM_SLV-1:0]          ack,
  input  logic [NUM_SLV*DATA_W-1:0]   rd_data_in,
  input  logic [NUM_SLV-1:0]          rd_valid_in,
  output logic [ADDR_W-1:0]           address,
  output logic [DATA_W-1:0]           data,
  output logic [NUM_SLV-1:0]          valid,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        rd_data_vld,
  output logic                        busy,
  output logic                        err,
  output logic                        drop
);
  localparam int SEL_W = $clog2(NUM_SLV);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, ACKLO, ERR} state_t;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           fv_q;
  logic                           cap_q, cap_d;
  logic [ADDR_W-1:0]              addr_q, addr_d;
  logic [DATA_W-1:0]              data_q, data_d;
  logic [NUM_SLV-1:0]             valid_q, valid_d;
  logic [DATA_W-1:0]              rd_q, rd_d;
  logic                           rdv_q, rdv_d;
  logic                           busy_q, busy_d;
  logic                           err_q, err_d;
  logic                           drop_q, drop_d;
  logic [NUM_SLV-1:0][DATA_W-1:0] rd_arr;
  logic [SEL_W-1:0]               sel, sel_new;
  logic                           fedge, live;

  assign rd_arr  = rd_data_in;
  assign fedge   = frame_valid & ~fv_q;
  assign sel     = addr_q[ADDR_W-1 -: SEL_W];
  assign sel_new = frame[ADDR_W+DATA_W-1 -: SEL_W];
  assign live    = (state_q == REQ) || (state_q == ACKLO);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    rd_d    = rd_q;
    rdv_d   = 1'b0;
    cap_d   = cap_q;
    err_d   = 1'b0;
    drop_d  = fedge && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        valid_d = '0;
        if (fedge) begin
          addr_d  = frame[ADDR_W+DATA_W-1:DATA_W];
          data_d  = frame[DATA_W-1:0];
          valid_d = NUM_SLV'(1) << sel_new;
          cap_d   = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack[sel]) begin
          valid_d = '0;
          cnt_d   = '0;
          state_d = ACKLO;
        end else if (cnt_q == CNT_LAST) begin
          valid_d = '0;
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACKLO: begin
        valid_d = '0;
        if (!ack[sel]) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        valid_d = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    // only the first read-back of a transaction is captured
    if (live && rd_valid_in[sel] && !cap_q) begin
      rd_d  = rd_arr[sel];
      rdv_d = 1'b1;
      cap_d = 1'b1;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fv_q    <= 1'b0;
      cap_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= '0;
      rd_q    <= '0;
      rdv_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fv_q    <= frame_valid;
      cap_q   <= cap_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      rd_q    <= rd_d;
      rdv_q   <= rdv_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  assign address     = addr_q;
  assign data        = data_q;
  assign valid       = valid_q;
  assign rd_data     = rd_q;
  assign rd_data_vld = rdv_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign drop        = drop_q;
endmodule

// File: tb/tb_reg_bus_router.sv
// Drives two router instances (default and wide parameter sets) with scripted
// and random transactions; expected waveforms come from closed-form timing rules.
module tb_reg_bus_router;
  localparam int TO0 = 15;
  localparam int TO1 = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] fr_w;
  logic        fv0, fv1;
  logic [7:0]  ack_w, rdv_w;
  logic [63:0] rdd_w;

  logic [3:0] o0_addr, o0_data, o0_valid, o0_rd;
  logic       o0_rdv, o0_busy, o0_err, o0_drop;
  logic [5:0] o1_addr;
  logic [7:0] o1_data, o1_valid, o1_rd;
  logic       o1_rdv, o1_busy, o1_err, o1_drop;

  int checks = 0;
  int errors = 0;
  int txn = 0;
  logic [63:0] exp_rd [2];

  always #5 clk = ~clk;

  reg_bus_router #(.ADDR_W(4), .DATA_W(4), .NUM_SLV(4), .TIMEOUT(TO0)) dut0 (
    .clk(clk), .rst(rst), .frame(fr_w[7:0]), .frame_valid(fv0), .ack(ack_w[3:0]),
    .rd_data_in(rdd_w[15:0]), .rd_valid_in(rdv_w[3:0]), .address(o0_addr), .data(o0_data),
    .valid(o0_valid), .rd_data(o0_rd), .rd_data_vld(o0_rdv), .busy(o0_busy),
    .err(o0_err), .drop(o0_drop));

  reg_bus_router #(.ADDR_W(6), .DATA_W(8), .NUM_SLV(8), .TIMEOUT(TO1)) dut1 (
    .clk(clk), .rst(rst), .frame(fr_w), .frame_valid(fv1), .ack(ack_w),
    .rd_data_in(rdd_w), .rd_valid_in(rdv_w), .address(o1_addr), .data(o1_data),
    .valid(o1_valid), .rd_data(o1_rd), .rd_data_vld(o1_rdv), .busy(o1_busy),
    .err(o1_err), .drop(o1_drop));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (txn %0d, t=%0t)", tag, obs, expv, txn, $time);
    end
  endtask

  // One transaction on instance u. a: REQ cycles before ack[sel] rises; h: ack high cycles;
  // r1<r2: cycles carrying a selected read-back pulse (0 = none); xin: cycle of an extra edge.
  task automatic run_txn(input int u, input logic [13:0] f, input int a, input int h,
                         input int r1, input int r2, input int xin,
                         input logic [7:0] dv1, input logic [7:0] dv2, input bit all_noise);
    int aw, dw, to, sw, sel, vend, endc, e, idle, k_end, rc, x;
    logic [63:0] addr, dat, onehot, rdval, mask, slice;
    bit fv_s;
    aw = u ? 6 : 4; dw = u ? 8 : 4; to = u ? TO1 : TO0; sw = u ? 3 : 2;
    mask   = (64'd1 << dw) - 1;
    addr   = (64'(f) >> dw) & ((64'd1 << aw) - 1);
    dat    = 64'(f) & mask;
    sel    = int'(addr >> (aw - sw));
    onehot = 64'd1 << sel;
    if (a >= to) begin
      e = 1; endc = to; vend = to;
    end else begin
      vend = a + 1;
      if (h >= to + 1) begin e = 1; endc = 1 + a + to; end
      else begin e = 0; endc = 1 + a + h; end
    end
    idle = endc + 1 + e;
    x = (xin >= 2 && xin <= endc + e) ? xin : 0;
    rc = 0; rdval = 0;
    if (r1 >= 1 && r1 <= endc) begin rc = r1; rdval = 64'(dv1); end
    else if (r2 >= 1 && r2 <= endc) begin rc = r2; rdval = 64'(dv2); end
    k_end = idle + 1;
    if (a + h + 1 > k_end) k_end = a + h + 1;
    txn++;
    for (int k = 0; k <= k_end; k++) begin
      fv_s  = (k == 0) || (x != 0 && k == x);
      fr_w  = (x != 0 && k == x) ? 14'($urandom) : f;
      fv0   = (u == 0) && fv_s;
      fv1   = (u == 1) && fv_s;
      ack_w = all_noise ? 8'hFF : 8'($urandom);
      ack_w[sel] = (k >= 1 + a) && (k <= a + h);
      rdv_w = 8'($urandom);
      rdv_w[sel] = (r1 != 0 && k == r1) || (r2 != 0 && k == r2);
      rdd_w = {$urandom, $urandom};
      slice = (r1 != 0 && k == r1) ? 64'(dv1) : (r2 != 0 && k == r2) ? 64'(dv2) : 64'($urandom);
      rdd_w = (rdd_w & ~(mask << (sel * dw))) | ((slice & mask) << (sel * dw));
      @(negedge clk);
      if (k >= 1) begin
        if (rc != 0 && k == rc + 1) exp_rd[u] = rdval & mask;
        chk("valid",   u ? 64'(o1_valid) : 64'(o0_valid), (k <= vend) ? onehot : 64'd0);
        chk("busy",    u ? 64'(o1_busy)  : 64'(o0_busy),  64'(k <= endc + e));
        chk("err",     u ? 64'(o1_err)   : 64'(o0_err),   64'(e == 1 && k == endc + 1));
        chk("drop",    u ? 64'(o1_drop)  : 64'(o0_drop),  64'(x != 0 && k == x + 1));
        chk("rd_vld",  u ? 64'(o1_rdv)   : 64'(o0_rdv),   64'(rc != 0 && k == rc + 1));
        chk("rd_data", u ? 64'(o1_rd)    : 64'(o0_rd),    exp_rd[u]);
        chk("address", u ? 64'(o1_addr)  : 64'(o0_addr),  addr);
        chk("data",    u ? 64'(o1_data)  : 64'(o0_data),  dat);
      end
      @(posedge clk); #1;
    end
    fv0 = 1'b0; fv1 = 1'b0; ack_w = '0; rdv_w = '0;
  endtask

  task automatic reset_mid_req(input int u, input logic [13:0] f, input logic [63:0] onehot);
    fr_w = f;
    if (u == 0) fv0 = 1'b1; else fv1 = 1'b1;
    ack_w = '0; rdv_w = '0;
    @(posedge clk); #1;
    fv0 = 1'b0; fv1 = 1'b0;
    @(negedge clk);
    chk("rst_pre_valid", u ? 64'(o1_valid) : 64'(o0_valid), onehot);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_valid", u ? 64'(o1_valid) : 64'(o0_valid), 64'd0);
    chk("rst_async_busy",  u ? 64'(o1_busy)  : 64'(o0_busy),  64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_rd[0] = 0; exp_rd[1] = 0;
    chk("rst_rd_data", u ? 64'(o1_rd) : 64'(o0_rd), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int u, a, h, r1, r2, x, to;
    rst = 1'b0; fr_w = '0; fv0 = 1'b0; fv1 = 1'b0; ack_w = '0; rdv_w = '0; rdd_w = '0;
    exp_rd[0] = 0; exp_rd[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid0", 64'(o0_valid), 64'd0);
    chk("reset_busy0",  64'(o0_busy),  64'd0);
    chk("reset_addr0",  64'(o0_addr),  64'd0);
    chk("reset_flags0", 64'({o0_err, o0_drop, o0_rdv}), 64'd0);
    chk("reset_valid1", 64'(o1_valid), 64'd0);
    chk("reset_data1",  64'(o1_data),  64'd0);
    chk("reset_rd1",    64'(o1_rd),    64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_txn(0, 14'h5A, 3, 2, 0, 0, 0, 8'h0, 8'h0, 1'b0);      // T1
    run_txn(0, 14'hC3, 99, 1, 0, 0, 0, 8'h0, 8'h0, 1'b0);     // T2 REQ timeout
    run_txn(0, 14'h07, 2, 1, 1, 0, 0, 8'h9, 8'h0, 1'b0);      // T3 read-back
    run_txn(0, 14'h96, 4, 3, 0, 0, 2, 8'h0, 8'h0, 1'b0);      // T4 drop in REQ
    run_txn(0, 14'h1B, 5, 2, 0, 0, 0, 8'h0, 8'h0, 1'b1);      // T5 foreign acks high
    run_txn(0, 14'h3C, 1, 20, 2, 3, 0, 8'h6, 8'hE, 1'b0);     // ACKLO timeout, first capture wins
    run_txn(0, 14'hE4, 0, 1, 0, 0, 0, 8'h0, 8'h0, 1'b0);      // ack already high
    run_txn(0, 14'h81, 14, 1, 0, 0, 0, 8'h0, 8'h0, 1'b0);     // ack on last allowed cycle
    run_txn(0, 14'h42, 99, 1, 16, 0, 16, 8'h5, 8'h0, 1'b0);   // drop + rd pulse in ERR cycle
    run_txn(0, 14'h6D, 2, 3, 0, 0, 6, 8'h0, 8'h0, 1'b0);      // drop on ACKLO->IDLE cycle
    reset_mid_req(0, 14'hE1, 64'h8);                          // T6 default params
    run_txn(0, 14'hB5, 2, 2, 3, 0, 0, 8'hC, 8'h0, 1'b0);

    reset_mid_req(1, 14'h2A5C, 64'h20);                       // T6 wide params
    run_txn(1, 14'h3F12, 3, 2, 2, 0, 0, 8'hA7, 8'h0, 1'b0);
    run_txn(1, 14'h0833, 99, 1, 0, 0, 7, 8'h0, 8'h0, 1'b0);
    run_txn(1, 14'h1501, 0, 9, 8, 0, 0, 8'h3C, 8'h0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      u  = int'($urandom_range(0, 1));
      to = u ? TO1 : TO0;
      a  = int'($urandom_range(0, to + 1));
      h  = int'($urandom_range(1, to + 2));
      r1 = int'($urandom_range(0, 10));
      r2 = (r1 == 0) ? 0 : r1 + int'($urandom_range(1, 4));
      x  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, to + 4)) : 0;
      run_txn(u, u ? 14'($urandom) : 14'($urandom_range(0, 255)), a, h, r1, r2, x,
              8'($urandom), 8'($urandom), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
